m_ice40sim_wbsram: RTL and testbench
====================================

// Module: m_ice40sim_wbsram
// PURPOSE
//  Behavioural Wishbone B4 slave SRAM for the midgetv iCE40 simulation benches, used with verilator.
//  Generalises the fixed SRAM bench: parametrised data width, depth, wait states and classic/pipelined
//  mode. Adds byte-lane writes, out-of-range ERR_O and an access counter for bench statistics.
//  Sits between the core's external-SRAM Wishbone master and the bench top.
// PARAMETERS
//  SRAMADRWIDTH  16  word-address width; depth = 2**SRAMADRWIDTH words
//  DWIDTH        32  data width, multiple of 8; NSEL = DWIDTH/8 byte lanes
//  WAITSTATES     1  extra cycles between request accept and ACK_O (0..15)
//  PIPELINED      0  0: Wishbone classic; 1: pipelined, uses STALL_O
//  MEMWORDS      2**SRAMADRWIDTH  implemented words; ADR_I >= MEMWORDS is out of range
// PORTS
//  CLK_I    in   1              single clock, rising edge
//  RSTN_I   in   1              asynchronous, active-low reset
//  CYC_I    in   1              bus cycle valid
//  STB_I    in   1              strobe
//  WE_I     in   1              1 = write
//  ADR_I    in   SRAMADRWIDTH   word address
//  SEL_I    in   NSEL           byte-lane enables, bit i = DAT[8i+7:8i]
//  DAT_I    in   DWIDTH         write data
//  DAT_O    out  DWIDTH         read data, valid while ACK_O
//  ACK_O    out  1              transfer done, one cycle per accepted request
//  ERR_O    out  1              out-of-range termination, replaces ACK_O
//  STALL_O  out  1              pipelined mode only; tied 0 when PIPELINED=0
//  nacc_O   out  16             accepted-request counter, wraps 16'hffff -> 0
// BEHAVIOUR
//  Reset (RSTN_I low, async): state IDLE, ACK_O=ERR_O=STALL_O=0, DAT_O=0, nacc_O=0, waitcnt=0.
//   Memory array is NOT cleared. Reset mid-access aborts it; a write not yet ACKed is not committed.
//  Accept: edge where CYC_I & STB_I & ~STALL_O and state allows (IDLE, or ACK in pipelined mode).
//   Latch WE/ADR/SEL/DAT. nacc_O increments.
//  FSM: IDLE -accept-> (WAITSTATES? WAIT : RESP); WAIT counts WAITSTATES-1..0 -> RESP;
//   RESP drives ACK_O (or ERR_O) for exactly one cycle, then IDLE, or a new accept in pipelined mode.
//  Latency: ACK_O high in cycle N+1+WAITSTATES for a request accepted at edge N.
//  Write: committed at the RESP edge, only lanes with SEL bit set change. SEL=0 writes nothing but still ACKs.
//  Read: DAT_O = mem[adr] registered into RESP. Lanes with SEL=0 return 0. DAT_O holds last value otherwise.
//  Out of range (adr >= MEMWORDS): no write, DAT_O=0, ERR_O instead of ACK_O, same latency.
//  Classic mode: STB_I still high during the RESP edge is not a new request. IDLE is always re-entered,
//   so at most one access per 2+WAITSTATES cycles.
//  Pipelined mode:
//   - STALL_O = (state==WAIT) | (state==RESP & WAITSTATES!=0).
//   - With WAITSTATES=0, back-to-back accept gives one ACK per cycle.
//  CYC_I drop before ACK: abort, state IDLE next edge, no ACK/ERR, pending write discarded.
//  Read after write to the same address in consecutive accesses returns the new data (no hazard).
// STRUCTURE
//  Shared package m_ice40sim_pkg: FSM state encoding (IDLE, WAIT, RESP), NSEL function,
//   waitcnt width constant (4).
//  One sub-module m_ice40sim_bytemem: NSEL-lane synchronous RAM, per-lane write enable.
//   Used for the memory array. FSM, counter and Wishbone logic stay in this module.
// TESTING
//  WAITSTATES=1, classic: write 32'hdeadbeef SEL=4'hf adr 5, read adr 5
//   -> each ACK exactly 2 cycles after accept, read DAT_O=32'hdeadbeef.
//  Byte lanes: mem[3]=32'h11223344, write 32'haabbccdd SEL=4'b0101, read SEL=4'hf
//   -> 32'h11bb33dd.
//  MEMWORDS=1000, read adr 1000 -> ERR_O one cycle, ACK_O=0, DAT_O=0; write adr 1000 leaves memory unchanged.
//  PIPELINED=1, WAITSTATES=0: 8 back-to-back reads -> 8 consecutive ACK cycles,
//   STALL_O always 0, nacc_O=8.
//  RSTN_I pulsed low during WAIT of a write (WAITSTATES=3)
//   -> ACK_O never asserted, target word unchanged, nacc_O=0.
//  nacc_O preset near wrap: 65537 accepts -> nacc_O=1.

Source files
------------

// File: rtl/m_ice40sim_pkg.sv
// m_ice40sim_pkg: shared FSM encoding, wait counter width and lane-count helper for the SRAM slave
package m_ice40sim_pkg;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  localparam int WCW = 4;
  function automatic int nsel(input int dw);
    return dw / 8;
  endfunction
endpackage

// File: rtl/m_ice40sim_bytemem.sv
// m_ice40sim_bytemem: byte-lane RAM with synchronous per-lane write and combinational read
module m_ice40sim_bytemem #(
  parameter int AW = 16,
  parameter int NSEL = 4
) (
  input  logic              clk,
  input  logic [NSEL-1:0]   we,
  input  logic [AW-1:0]     wadr,
  input  logic [8*NSEL-1:0] wdat,
  input  logic [AW-1:0]     radr,
  output logic [8*NSEL-1:0] rdat
);
  logic [8*NSEL-1:0] mem [2**AW];
  always_ff @(posedge clk)
    for (int i = 0; i < NSEL; i++)
      if (we[i]) mem[wadr][8*i+:8] <= wdat[8*i+:8];
  assign rdat = mem[radr];
endmodule

// File: rtl/m_ice40sim_wbsram.sv
// m_ice40sim_wbsram: Wishbone B4 SRAM slave with wait states, byte lanes, range check and access counter
module m_ice40sim_wbsram
  import m_ice40sim_pkg::*;
#(
  parameter int SRAMADRWIDTH = 16,
  parameter int DWIDTH = 32,
  parameter int WAITSTATES = 1,
  parameter int PIPELINED = 0,
  parameter int MEMWORDS = 2 ** SRAMADRWIDTH
) (
  input  logic                      CLK_I,
  input  logic                      RSTN_I,
  input  logic                      CYC_I,
  input  logic                      STB_I,
  input  logic                      WE_I,
  input  logic [SRAMADRWIDTH-1:0]   ADR_I,
  input  logic [nsel(DWIDTH)-1:0]   SEL_I,
  input  logic [DWIDTH-1:0]         DAT_I,
  output logic [DWIDTH-1:0]         DAT_O,
  output logic                      ACK_O,
  output logic                      ERR_O,
  output logic                      STALL_O,
  output logic [15:0]               nacc_O
);
  localparam int NSEL = nsel(DWIDTH);
  localparam state_t S_ACC = state_t'(WAITSTATES == 0 ? S_RESP : S_WAIT);
  state_t state, state_n;
  logic [WCW-1:0] waitcnt;
  logic we_r, oor_r, accept, go_resp, commit, ld_we, ld_oor;
  logic [SRAMADRWIDTH-1:0] adr_r, ld_adr;
  logic [NSEL-1:0] sel_r, ld_sel, mem_we;
  logic [DWIDTH-1:0] dat_r, rdat, rd_m;
  assign STALL_O = PIPELINED != 0 && (state == S_WAIT || (state == S_RESP && WAITSTATES != 0));
  assign accept  = CYC_I && STB_I && !STALL_O && (state == S_IDLE || (PIPELINED != 0 && state == S_RESP));
  assign go_resp = WAITSTATES == 0 ? accept : state == S_WAIT && CYC_I && waitcnt == '0;
  // with no wait states the request entering RESP is the one on the bus right now
  assign ld_we   = WAITSTATES == 0 ? WE_I : we_r;
  assign ld_adr  = WAITSTATES == 0 ? ADR_I : adr_r;
  assign ld_sel  = WAITSTATES == 0 ? SEL_I : sel_r;
  assign ld_oor  = WAITSTATES == 0 ? 32'(ADR_I) >= 32'(MEMWORDS) : oor_r;
  assign commit  = state == S_RESP && we_r && !oor_r;
  assign mem_we  = commit ? sel_r : '0;
  assign ACK_O   = state == S_RESP && !oor_r;
  assign ERR_O   = state == S_RESP && oor_r;
  always_comb
    state_n = state == S_IDLE ? (accept ? S_ACC : S_IDLE) :
              state == S_WAIT ? (!CYC_I ? S_IDLE : waitcnt == '0 ? S_RESP : S_WAIT) :
              (accept ? S_ACC : S_IDLE);
  // back-to-back pipelined write then read of the same word: forward the committing lanes
  always_comb begin
    rd_m = rdat;
    for (int k = 0; k < NSEL; k++) begin
      if (commit && adr_r == ld_adr && sel_r[k]) rd_m[8*k+:8] = dat_r[8*k+:8];
      if (!ld_sel[k]) rd_m[8*k+:8] = '0;
    end
  end
  m_ice40sim_bytemem #(.AW(SRAMADRWIDTH), .NSEL(NSEL)) u_mem (
    .clk(CLK_I), .we(mem_we), .wadr(adr_r), .wdat(dat_r), .radr(ld_adr), .rdat(rdat)
  );
  always_ff @(posedge CLK_I or negedge RSTN_I)
    if (!RSTN_I) begin
      state   <= S_IDLE;
      waitcnt <= '0;
      DAT_O   <= '0;
      nacc_O  <= '0;
      we_r    <= 1'b0;
      oor_r   <= 1'b0;
      adr_r   <= '0;
      sel_r   <= '0;
      dat_r   <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        waitcnt <= WCW'(WAITSTATES == 0 ? 0 : WAITSTATES - 1);
        we_r    <= WE_I;
        oor_r   <= 32'(ADR_I) >= 32'(MEMWORDS);
        adr_r   <= ADR_I;
        sel_r   <= SEL_I;
        dat_r   <= DAT_I;
        nacc_O  <= nacc_O + 1'b1;
      end else if (state == S_WAIT) waitcnt <= waitcnt - 1'b1;
      if (go_resp && (ld_oor || !ld_we)) DAT_O <= ld_oor ? '0 : rd_m;
    end
endmodule

// File: tb/tb_m_ice40sim_wbsram.sv
// tb_m_ice40sim_wbsram: three slave configurations checked against a cycle-level transaction model
module tb_m_ice40sim_wbsram;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic cyc[3], stb[3], we[3], ack[3], err[3], stall[3];
  logic [9:0] adr[3];
  logic [3:0] sel[3];
  logic [31:0] dati[3], dato[3];
  logic [15:0] nacc[3];
  int checks = 0, errors = 0;

  m_ice40sim_wbsram #(.SRAMADRWIDTH(10), .WAITSTATES(1), .PIPELINED(0), .MEMWORDS(1000)) u0 (
    .CLK_I(clk), .RSTN_I(rst_n), .CYC_I(cyc[0]), .STB_I(stb[0]), .WE_I(we[0]), .ADR_I(adr[0]),
    .SEL_I(sel[0]), .DAT_I(dati[0]), .DAT_O(dato[0]), .ACK_O(ack[0]), .ERR_O(err[0]),
    .STALL_O(stall[0]), .nacc_O(nacc[0]));
  m_ice40sim_wbsram #(.SRAMADRWIDTH(10), .WAITSTATES(0), .PIPELINED(1)) u1 (
    .CLK_I(clk), .RSTN_I(rst_n), .CYC_I(cyc[1]), .STB_I(stb[1]), .WE_I(we[1]), .ADR_I(adr[1]),
    .SEL_I(sel[1]), .DAT_I(dati[1]), .DAT_O(dato[1]), .ACK_O(ack[1]), .ERR_O(err[1]),
    .STALL_O(stall[1]), .nacc_O(nacc[1]));
  m_ice40sim_wbsram #(.SRAMADRWIDTH(10), .WAITSTATES(3), .PIPELINED(0)) u2 (
    .CLK_I(clk), .RSTN_I(rst_n), .CYC_I(cyc[2]), .STB_I(stb[2]), .WE_I(we[2]), .ADR_I(adr[2]),
    .SEL_I(sel[2]), .DAT_I(dati[2]), .DAT_O(dato[2]), .ACK_O(ack[2]), .ERR_O(err[2]),
    .STALL_O(stall[2]), .nacc_O(nacc[2]));

  function automatic int ws_of(input int d);
    return d == 0 ? 1 : d == 1 ? 0 : 3;
  endfunction
  function automatic bit pipe_of(input int d);
    return d == 1;
  endfunction
  function automatic int mw_of(input int d);
    return d == 0 ? 1000 : 1024;
  endfunction

  task automatic chk(input string n, input int d, input logic [31:0] a, input logic [31:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s[%0d] got %h want %h at %0t", n, d, a, x, $time);
    end
  endtask

  // Transaction model: one outstanding request per slave, response edge = accept edge + 1 + WAITSTATES.
  int e = 0;
  bit pv[3], pwe[3], poor[3], ek[3];
  int pa[3], fr[3], padr[3];
  logic [3:0] psel[3];
  logic [31:0] pdat[3], ed[3];
  logic [15:0] mn[3];
  logic [31:0] mm[3072];
  logic [3:0] mk[3072];

  initial begin
    for (int i = 0; i < 3072; i++) mk[i] = 4'h0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int d = 0; d < 3; d++) begin
          pv[d] = 0; fr[d] = 0; mn[d] = 16'h0; ed[d] = 32'h0; ek[d] = 1;
        end
      end else begin
        e++;
        for (int d = 0; d < 3; d++) begin
          if (pv[d] && pa[d] == e) begin
            if (pwe[d] && !poor[d])
              for (int l = 0; l < 4; l++)
                if (psel[d][l]) begin
                  mm[d*1024+padr[d]][8*l+:8] = pdat[d][8*l+:8];
                  mk[d*1024+padr[d]][l] = 1'b1;
                end
            pv[d] = 0;
          end else if (pv[d] && !cyc[d]) begin
            pv[d] = 0;
            fr[d] = e + 1;
          end
          if (cyc[d] && stb[d] && e >= fr[d]) begin
            pv[d] = 1; pa[d] = e + 1 + ws_of(d); pwe[d] = we[d]; padr[d] = int'(adr[d]);
            poor[d] = padr[d] >= mw_of(d); psel[d] = sel[d]; pdat[d] = dati[d];
            mn[d] = mn[d] + 16'h1;
            fr[d] = e + ((pipe_of(d) && ws_of(d) == 0) ? 1 : 2 + ws_of(d));
          end
          if (pv[d] && pa[d] - 1 == e && (poor[d] || !pwe[d])) begin
            ed[d] = 32'h0; ek[d] = 1;
            if (!poor[d])
              for (int l = 0; l < 4; l++)
                if (psel[d][l]) begin
                  ed[d][8*l+:8] = mm[d*1024+padr[d]][8*l+:8];
                  if (!mk[d*1024+padr[d]][l]) ek[d] = 0;
                end
          end
        end
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("ack", d, 32'(ack[d]), 32'(pv[d] && pa[d] == e + 1 && !poor[d]));
      chk("err", d, 32'(err[d]), 32'(pv[d] && pa[d] == e + 1 && poor[d]));
      chk("stall", d, 32'(stall[d]), 32'(pipe_of(d) && ws_of(d) != 0 && pv[d]));
      chk("nacc", d, 32'(nacc[d]), 32'(mn[d]));
      if (ek[d]) chk("dat", d, dato[d], ed[d]);
    end
  end

  task automatic xfer(input int d, input bit w, input int a, input logic [3:0] s, input logic [31:0] v,
                      output logic [31:0] rd, output int lat, output bit er);
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = 10'(a); sel[d] = s; dati[d] = v;
    @(posedge clk);
    @(negedge clk);
    lat = 1;
    while (!(ack[d] || err[d]) && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rd = dato[d];
    er = err[d];
    @(negedge clk);
    cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
  endtask

  task automatic pipe(input int d, input int n, input int a0, input int stride, input logic [31:0] wmask,
                      input logic [31:0] v0, output int acks, output int stalls, output logic [31:0] last);
    acks = 0; stalls = 0; last = 32'h0;
    cyc[d] = 1'b1; stb[d] = 1'b1; sel[d] = 4'hf;
    adr[d] = 10'(a0); we[d] = wmask[0]; dati[d] = v0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (ack[d]) begin
        acks++;
        last = dato[d];
      end
      if (stall[d]) stalls++;
      if (i + 1 < n) begin
        adr[d] = 10'(a0 + (i + 1) * stride);
        we[d] = (i + 1 < 32) && wmask[5'(i + 1)];
        dati[d] = v0 + 32'(i + 1);
      end else begin
        stb[d] = 1'b0; we[d] = 1'b0;
      end
    end
    repeat (2) begin
      @(negedge clk);
      if (ack[d]) acks++;
    end
    cyc[d] = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    int lat, acks, stalls, na;
    bit er;
    for (int d = 0; d < 3; d++) begin
      cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0; adr[d] = '0; sel[d] = '0; dati[d] = '0;
    end
    repeat (3) @(negedge clk);
    chk("rst_nacc", 0, 32'(nacc[0]), 32'h0);
    chk("rst_dat", 2, dato[2], 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    xfer(0, 1, 5, 4'hf, 32'hdeadbeef, rd, lat, er);
    chk("wr_lat", 0, 32'(lat), 32'd2);
    xfer(0, 0, 5, 4'hf, 32'h0, rd, lat, er);
    chk("rd_lat", 0, 32'(lat), 32'd2);
    chk("rd_dat", 0, rd, 32'hdeadbeef);
    xfer(0, 1, 3, 4'hf, 32'h11223344, rd, lat, er);
    xfer(0, 1, 3, 4'b0101, 32'haabbccdd, rd, lat, er);
    xfer(0, 0, 3, 4'hf, 32'h0, rd, lat, er);
    chk("lane_dat", 0, rd, 32'h11bb33dd);
    xfer(0, 0, 3, 4'b0011, 32'h0, rd, lat, er);
    chk("lane_mask", 0, rd, 32'h000033dd);
    xfer(0, 0, 1000, 4'hf, 32'h0, rd, lat, er);
    chk("oor_err", 0, 32'(er), 32'd1);
    chk("oor_dat", 0, rd, 32'h0);
    chk("oor_lat", 0, 32'(lat), 32'd2);
    xfer(0, 1, 1000, 4'hf, 32'h55555555, rd, lat, er);
    chk("oor_wr_err", 0, 32'(er), 32'd1);
    xfer(0, 1, 5, 4'h0, 32'h0, rd, lat, er);
    chk("sel0_err", 0, 32'(er), 32'd0);
    chk("sel0_lat", 0, 32'(lat), 32'd2);
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; adr[0] = 10'd5; sel[0] = 4'hf; dati[0] = 32'h0;
    @(posedge clk);
    @(negedge clk);
    cyc[0] = 1'b0; stb[0] = 1'b0; we[0] = 1'b0;
    na = 0;
    repeat (3) begin
      @(negedge clk);
      if (ack[0] || err[0]) na++;
    end
    chk("abort_ack", 0, 32'(na), 32'd0);
    xfer(0, 0, 5, 4'hf, 32'h0, rd, lat, er);
    chk("abort_keep", 0, rd, 32'hdeadbeef);
    pipe(1, 8, 'h20, 1, 32'h0, 32'h0, acks, stalls, rd);
    chk("p_acks", 1, 32'(acks), 32'd8);
    chk("p_stall", 1, 32'(stalls), 32'd0);
    chk("p_nacc", 1, 32'(nacc[1]), 32'd8);
    pipe(1, 2, 'h10, 0, 32'h1, 32'h5a5a0001, acks, stalls, rd);
    chk("raw_acks", 1, 32'(acks), 32'd2);
    chk("raw_dat", 1, rd, 32'h5a5a0001);
    xfer(2, 1, 7, 4'hf, 32'h12345678, rd, lat, er);
    chk("ws3_lat", 2, 32'(lat), 32'd4);
    cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; adr[2] = 10'd7; sel[2] = 4'hf; dati[2] = 32'hcafef00d;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    cyc[2] = 1'b0; stb[2] = 1'b0; we[2] = 1'b0;
    na = 0;
    repeat (2) begin
      @(negedge clk);
      if (ack[2]) na++;
    end
    chk("rst_nacc2", 2, 32'(nacc[2]), 32'h0);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (ack[2]) na++;
    end
    chk("rst_noack", 2, 32'(na), 32'd0);
    xfer(2, 0, 7, 4'hf, 32'h0, rd, lat, er);
    chk("rst_keep", 2, rd, 32'h12345678);
    pipe(1, 65537, 'h10, 0, 32'h0, 32'h0, acks, stalls, rd);
    chk("wrap_acks", 1, 32'(acks), 32'd65537);
    chk("wrap_nacc", 1, 32'(nacc[1]), 32'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
